// File: rtl/nnfc_pkg.sv
// Shared definitions for the layer sequencer and the weight fetch path.
package nnfc_pkg;

   localparam int ADDR_W   = 10;
   localparam int NO_LANES = 4;
   localparam int LAYER_W  = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/weight_fifo.sv
// Prefetch buffer between weight memory and the MAC lanes; a push and a pop
// in the same cycle are both honoured.
module weight_fifo #(
   parameter  int WIDTH      = 64,
   parameter  int FIFO_DEPTH = 4,
   localparam int PTR_W      = $clog2(FIFO_DEPTH),
   localparam int CNT_W      = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(FIFO_DEPTH)) || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head      = mem_q[rd_ptr_q];
   assign not_empty = (count_q != '0);
   assign count     = count_q;

endmodule

// File: rtl/weight_fetch.sv
// Strided weight prefetch from fixed-latency memory into a small FIFO feeding
// the MAC lanes. Sticky underrun detection is built when WEIGHT_FETCH_UNDERRUN_CHK_EN is defined.
module weight_fetch #(
   parameter int ADDR_W      = nnfc_pkg::ADDR_W,
   parameter int DATA_W      = 16,
   parameter int NO_LANES    = nnfc_pkg::NO_LANES,
   parameter int FIFO_DEPTH  = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         arb_en,
   input  logic [ADDR_W-1:0]            base_addr,
   input  logic [ADDR_W-1:0]            start_offset,
   input  logic [ADDR_W-1:0]            stride,
   input  logic [10:0]                  fetch_len,
   input  logic [nnfc_pkg::LAYER_W-1:0] layer_no,
   input  logic [NO_LANES-1:0]          rd_en,
   output logic                         mem_req,
   output logic [ADDR_W-1:0]            mem_addr,
   input  logic [NO_LANES*DATA_W-1:0]   mem_rdata,
   output logic [NO_LANES*DATA_W-1:0]   w_data,
   output logic                         w_valid,
   output logic [nnfc_pkg::LAYER_W-1:0] cur_layer,
   output logic                         busy,
   output logic                         done,
   output logic                         underrun
);

   import nnfc_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e         state_q, state_d;
   logic                 arb_en_q;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [ADDR_W-1:0]    stride_q, stride_d;
   logic [10:0]          remaining_q, remaining_d;
   logic [LAYER_W-1:0]   cur_layer_q, cur_layer_d;
   logic                 mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
   logic                 done_q, done_d;
   logic [MEM_LATENCY-1:0] vld_q;

   logic                 start, push, pop, fifo_valid, credit_ok, drain_empty;
   logic [ADDR_W-1:0]    first_addr;
   logic [CNT_W-1:0]     fifo_count;
   int                   outstanding;

   assign push = vld_q[MEM_LATENCY-1];
   assign pop  = (|rd_en) && fifo_valid;

   weight_fifo #(
      .WIDTH      (NO_LANES*DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (mem_rdata),
      .pop       (pop),
      .head      (w_data),
      .not_empty (fifo_valid),
      .count     (fifo_count)
   );

   // Credits cover the request being driven, words in the memory pipe and
   // FIFO entries; a pop this cycle frees its slot in time for the new word.
   always_comb begin
      start       = arb_en && !arb_en_q;
      first_addr  = base_addr + start_offset;
      outstanding = 32'(mem_req_q) + 32'($countones(vld_q)) + 32'(fifo_count) - 32'(pop);
      credit_ok   = (outstanding < FIFO_DEPTH);
      drain_empty = !mem_req_q && (vld_q == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop));

      state_d     = state_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      remaining_d = remaining_q;
      cur_layer_d = cur_layer_q;
      mem_req_d   = 1'b0;
      mem_addr_d  = mem_addr_q;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               stride_d    = stride;
               cur_layer_d = layer_no;
               if (fetch_len == 11'd0) begin
                  remaining_d = 11'd0;
                  addr_d      = first_addr;
                  state_d     = DRAIN;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_addr_d  = first_addr;
                  addr_d      = first_addr + stride;
                  remaining_d = fetch_len - 11'd1;
                  state_d     = (fetch_len == 11'd1) ? DRAIN : FETCH;
               end
            end
         end
         FETCH: begin
            if (credit_ok) begin
               mem_req_d   = 1'b1;
               mem_addr_d  = addr_q;
               addr_d      = addr_q + stride_q;
               remaining_d = remaining_q - 11'd1;
               if (remaining_q == 11'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         arb_en_q    <= 1'b0;
         addr_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
         cur_layer_q <= '0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         done_q      <= 1'b0;
         vld_q       <= '0;
      end else begin
         state_q     <= state_d;
         arb_en_q    <= arb_en;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         remaining_q <= remaining_d;
         cur_layer_q <= cur_layer_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         done_q      <= done_d;
         vld_q[0]    <= mem_req_q;
         for (int i = 1; i < MEM_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
   end

`ifdef WEIGHT_FETCH_UNDERRUN_CHK_EN
   logic underrun_q, underrun_d;

   always_comb underrun_d = underrun_q || ((|rd_en) && !fifo_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) underrun_q <= 1'b0;
      else      underrun_q <= underrun_d;
   end

   assign underrun = underrun_q;
`else
   assign underrun = 1'b0;
`endif

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign cur_layer = cur_layer_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign w_valid   = fifo_valid;

endmodule
